// File: rtl/prog_seq_pkg.sv
// Purpose: shared types and constants for the program run controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prog_seq_pkg;

    // Run controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // ProgIdx is 2 bits wide, so the ROM can hold at most four programs.
    localparam int PROG_SLOTS = 4;

    // Entry point of each program in instruction ROM.
    localparam logic [7:0] PROG_BASE [0:PROG_SLOTS-1] = '{8'h00, 8'h30, 8'h68, 8'hA0};

    localparam int DEF_NUM_PROGS  = 3;
    localparam int DEF_RST_CYCLES = 2;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_MAX_CYCLES = 'hFFFF;

endpackage

// File: rtl/sat_counter.sv
// Purpose: up-counter that sticks at LIMIT; clear has priority over enable.
// Latency: count updates one cycle after clear/enable are sampled.
// Backpressure: none; enable is honoured every cycle until LIMIT is reached.
// Ports: clk, rst_n (sync, active-low), clear, enable -> count, at_limit.
module sat_counter #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] LIMIT = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] LIMIT_M1 = LIMIT - WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + WIDTH'(1);
        end
    end

    // High when the next enabled increment lands exactly on LIMIT, so the
    // owner can decide on the final cycle instead of one cycle late.
    assign at_limit = (count == LIMIT_M1);

endmodule

// File: rtl/prog_sequencer.sv
// Purpose: run controller; four-phase Start/Ack with the host, holds the core in reset between runs.
// Latency: Start -> core released after RST_CYCLES; done/watchdog -> Ack next cycle; Abort -> core reset next cycle.
// Backpressure: a new run is not accepted until Start has been seen low in DONE.
// Ports: Clk, Reset (sync, active-low), Start, Abort, CoreAck -> CoreReset, StartAddr, ProgIdx,
//        Busy, Ack, Timeout, CycleCount. All outputs come straight from flops.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int               NUM_PROGS  = DEF_NUM_PROGS,
    parameter int               RST_CYCLES = DEF_RST_CYCLES,
    parameter int               CNT_W      = DEF_CNT_W,
    parameter logic [CNT_W-1:0] MAX_CYCLES = CNT_W'(DEF_MAX_CYCLES)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Abort,
    input  logic             CoreAck,
    output logic             CoreReset,
    output logic [7:0]       StartAddr,
    output logic [1:0]       ProgIdx,
    output logic             Busy,
    output logic             Ack,
    output logic             Timeout,
    output logic [CNT_W-1:0] CycleCount
);

    localparam int              HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_CYCLES - 1);
    localparam logic [1:0]      LAST_IDX  = 2'(NUM_PROGS - 1);

    state_t            state;
    logic [HOLD_W-1:0] hold;
    logic [1:0]        nxt_idx;
    logic              cnt_clear;
    logic              cnt_en;
    logic              cnt_at_limit;

    assign nxt_idx   = (ProgIdx == LAST_IDX) ? 2'd0 : ProgIdx + 2'd1;
    assign cnt_clear = (state == ST_IDLE) && Start;
    // The cycle that sees Abort or CoreAck still counts as a RUN cycle.
    assign cnt_en    = (state == ST_RUN);

    sat_counter #(
        .WIDTH (CNT_W),
        .LIMIT (MAX_CYCLES)
    ) u_cycle_cnt (
        .clk      (Clk),
        .rst_n    (Reset),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .count    (CycleCount),
        .at_limit (cnt_at_limit)
    );

    // State and the decoded control outputs are updated together so every
    // output is a flop with no input-to-output path.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            hold      <= '0;
            ProgIdx   <= 2'd0;
            StartAddr <= PROG_BASE[0];
            CoreReset <= 1'b1;
            Busy      <= 1'b0;
            Ack       <= 1'b0;
            Timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        state   <= ST_RESET;
                        hold    <= HOLD_INIT;
                        Busy    <= 1'b1;
                        Timeout <= 1'b0;
                    end
                end
                ST_RESET: begin
                    if (Abort) begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                    end else if (hold == '0) begin
                        state     <= ST_RUN;
                        CoreReset <= 1'b0;
                    end else begin
                        hold <= hold - 1'b1;
                    end
                end
                ST_RUN: begin
                    // Abort beats a done flag; a done flag beats the watchdog.
                    if (Abort) begin
                        state     <= ST_IDLE;
                        CoreReset <= 1'b1;
                        Busy      <= 1'b0;
                    end else if (CoreAck || cnt_at_limit) begin
                        state     <= ST_DONE;
                        CoreReset <= 1'b1;
                        Busy      <= 1'b0;
                        Ack       <= 1'b1;
                        Timeout   <= !CoreAck;
                    end
                end
                ST_DONE: begin
                    // Require the low phase of Start before another run.
                    if (!Start) begin
                        state     <= ST_IDLE;
                        Ack       <= 1'b0;
                        ProgIdx   <= nxt_idx;
                        StartAddr <= PROG_BASE[nxt_idx];
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Purpose: self-checking bench for prog_sequencer with a run-outcome reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_prog_sequencer;

    localparam int NP = 3;
    localparam int RC = 2;
    localparam int MC = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          core_ack = 1'b0;
    logic          core_reset;
    logic [7:0]    start_addr;
    logic [1:0]    prog_idx;
    logic          busy;
    logic          ack;
    logic          timeout;
    logic [CW-1:0] cycle_count;

    logic [7:0] exp_base [0:3] = '{8'h00, 8'h30, 8'h68, 8'hA0};

    int errors = 0;
    int checks = 0;
    int exp_idx = 0;

    prog_sequencer #(
        .NUM_PROGS  (NP),
        .RST_CYCLES (RC),
        .CNT_W      (CW),
        .MAX_CYCLES (16'(MC))
    ) dut (
        .Clk        (clk),
        .Reset      (rst_n),
        .Start      (start),
        .Abort      (abort),
        .CoreAck    (core_ack),
        .CoreReset  (core_reset),
        .StartAddr  (start_addr),
        .ProgIdx    (prog_idx),
        .Busy       (busy),
        .Ack        (ack),
        .Timeout    (timeout),
        .CycleCount (cycle_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench did not complete");
    end

    // Outcome of one run from the rules: the earliest of abort, done flag and
    // watchdog limit ends it; abort wins ties, done flag beats the limit.
    function automatic void model_run(input int ack_at, input int abort_at,
                                      output int cnt, output bit aborted, output bit tmo);
        int e_ack;
        int e_abt;
        e_ack   = (ack_at == 0) ? 1000 : ack_at;
        e_abt   = (abort_at == 0) ? 1000 : abort_at;
        cnt     = MC;
        if (e_ack < cnt) cnt = e_ack;
        if (e_abt < cnt) cnt = e_abt;
        aborted = (e_abt == cnt);
        tmo     = !aborted && (e_ack > MC);
    endfunction

    // Starts a run from IDLE at a negedge, measures reset-hold and RUN lengths,
    // raising CoreAck/Abort on the requested RUN cycle (1 = first, 0 = never).
    task automatic do_run(input int ack_at, input int abort_at, input bit hold_start,
                          output int rst_seen, output int run_seen);
        int guard;
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        rst_seen = 0;
        guard    = 0;
        while (core_reset && busy && guard < 20) begin
            rst_seen++;
            guard++;
            @(negedge clk);
        end
        run_seen = 0;
        guard    = 0;
        while (busy && !core_reset && guard < 100) begin
            run_seen++;
            guard++;
            core_ack = (run_seen == ack_at);
            abort    = (run_seen == abort_at);
            @(negedge clk);
        end
        core_ack = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({core_reset, busy, ack, timeout} !== 4'b1000) begin
                errors++;
                $display("FAIL reset_ctl[%0d]: got %b want 1000", i, {core_reset, busy, ack, timeout});
            end
            checks++;
            if (cycle_count !== 16'd0) begin
                errors++;
                $display("FAIL reset_count[%0d]: got %0d want 0", i, cycle_count);
            end
            checks++;
            if (prog_idx !== 2'd0 || start_addr !== exp_base[0]) begin
                errors++;
                $display("FAIL reset_prog[%0d]: got idx %0d addr %h want 0 %h", i, prog_idx, start_addr, exp_base[0]);
            end
        end
    endtask

    task automatic test_basic_run;
        int r;
        int n;
        do_run(5, 0, 1'b0, r, n);
        checks++;
        if (r != RC) begin
            errors++;
            $display("FAIL basic_reset_len: got %0d want %0d", r, RC);
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL basic_run_len: got %0d want 5", n);
        end
        checks++;
        if ({ack, busy, core_reset, timeout} !== 4'b1010) begin
            errors++;
            $display("FAIL basic_done_ctl: got %b want 1010", {ack, busy, core_reset, timeout});
        end
        checks++;
        if (cycle_count !== 16'd5) begin
            errors++;
            $display("FAIL basic_count: got %0d want 5", cycle_count);
        end
        @(negedge clk);
        exp_idx = (exp_idx + 1) % NP;
        checks++;
        if (ack !== 1'b0 || prog_idx !== 2'(exp_idx) || start_addr !== exp_base[exp_idx]) begin
            errors++;
            $display("FAIL basic_advance: got ack %b idx %0d addr %h want 0 %0d %h",
                     ack, prog_idx, start_addr, exp_idx, exp_base[exp_idx]);
        end
    endtask

    task automatic test_timeout;
        int r;
        int n;
        int guard;
        do_run(0, 0, 1'b0, r, n);
        checks++;
        if (n != MC || cycle_count !== 16'(MC)) begin
            errors++;
            $display("FAIL tmo_len: got run %0d count %0d want %0d", n, cycle_count, MC);
        end
        checks++;
        if (timeout !== 1'b1 || ack !== 1'b1) begin
            errors++;
            $display("FAIL tmo_flag: got timeout %b ack %b want 1 1", timeout, ack);
        end
        @(negedge clk);
        exp_idx = (exp_idx + 1) % NP;
        checks++;
        if (timeout !== 1'b1 || prog_idx !== 2'(exp_idx)) begin
            errors++;
            $display("FAIL tmo_sticky: got timeout %b idx %0d want 1 %0d", timeout, prog_idx, exp_idx);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b1 || cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL tmo_clear: got timeout %b busy %b count %0d want 0 1 0", timeout, busy, cycle_count);
        end
        guard = 0;
        while (busy && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        @(negedge clk);
        exp_idx = (exp_idx + 1) % NP;
    endtask

    task automatic test_ack_at_limit;
        int r;
        int n;
        do_run(MC, 0, 1'b0, r, n);
        checks++;
        if (timeout !== 1'b0 || ack !== 1'b1 || cycle_count !== 16'(MC)) begin
            errors++;
            $display("FAIL ack_limit: got timeout %b ack %b count %0d want 0 1 %0d", timeout, ack, cycle_count, MC);
        end
        @(negedge clk);
        exp_idx = (exp_idx + 1) % NP;
    endtask

    task automatic test_prog_wrap;
        int r;
        int n;
        for (int i = 0; i < 3; i++) begin
            do_run(int'($urandom_range(1, 6)), 0, 1'b0, r, n);
            @(negedge clk);
            exp_idx = (exp_idx + 1) % NP;
            checks++;
            if (prog_idx !== 2'(exp_idx) || start_addr !== exp_base[exp_idx]) begin
                errors++;
                $display("FAIL wrap[%0d]: got idx %0d addr %h want %0d %h",
                         i, prog_idx, start_addr, exp_idx, exp_base[exp_idx]);
            end
        end
    endtask

    task automatic test_start_held;
        int r;
        int n;
        do_run(2, 0, 1'b1, r, n);
        for (int i = 0; i < 4; i++) begin
            abort = (i == 1);
            @(negedge clk);
            checks++;
            if ({ack, busy, core_reset} !== 3'b101) begin
                errors++;
                $display("FAIL held_done[%0d]: got %b want 101", i, {ack, busy, core_reset});
            end
        end
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        exp_idx = (exp_idx + 1) % NP;
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0 || prog_idx !== 2'(exp_idx)) begin
            errors++;
            $display("FAIL held_release: got ack %b busy %b idx %0d want 0 0 %0d", ack, busy, prog_idx, exp_idx);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || core_reset !== 1'b1) begin
            errors++;
            $display("FAIL idle_abort: got busy %b core_reset %b want 0 1", busy, core_reset);
        end
    endtask

    task automatic test_abort;
        int r;
        int n;
        do_run(0, 3, 1'b0, r, n);
        checks++;
        if (n != 3 || cycle_count !== 16'd3) begin
            errors++;
            $display("FAIL abort_count: got run %0d count %0d want 3", n, cycle_count);
        end
        checks++;
        if ({busy, core_reset, ack} !== 3'b010 || prog_idx !== 2'(exp_idx)) begin
            errors++;
            $display("FAIL abort_state: got %b idx %0d want 010 %0d", {busy, core_reset, ack}, prog_idx, exp_idx);
        end
    endtask

    task automatic test_random;
        int r;
        int n;
        int ack_at;
        int abort_at;
        int exp_cnt;
        bit exp_abt;
        bit exp_tmo;
        for (int i = 0; i < 20; i++) begin
            ack_at   = int'($urandom_range(0, 10));
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0;
            model_run(ack_at, abort_at, exp_cnt, exp_abt, exp_tmo);
            do_run(ack_at, abort_at, 1'b0, r, n);
            checks++;
            if (n != exp_cnt || cycle_count !== 16'(exp_cnt)) begin
                errors++;
                $display("FAIL rand_count[%0d] ack %0d abort %0d: got run %0d count %0d want %0d",
                         i, ack_at, abort_at, n, cycle_count, exp_cnt);
            end
            checks++;
            if (ack !== !exp_abt || busy !== 1'b0 || (!exp_abt && timeout !== exp_tmo)) begin
                errors++;
                $display("FAIL rand_end[%0d] ack %0d abort %0d: got ack %b busy %b timeout %b want %b 0 %b",
                         i, ack_at, abort_at, ack, busy, timeout, !exp_abt, exp_tmo);
            end
            if (!exp_abt) begin
                @(negedge clk);
                exp_idx = (exp_idx + 1) % NP;
            end
            checks++;
            if (prog_idx !== 2'(exp_idx)) begin
                errors++;
                $display("FAIL rand_idx[%0d]: got %0d want %0d", i, prog_idx, exp_idx);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        int r;
        int n;
        int guard;
        if (exp_idx == 0) begin
            do_run(1, 0, 1'b0, r, n);
            @(negedge clk);
            exp_idx = 1;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (core_reset && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_idx = 0;
        checks++;
        if ({core_reset, busy, ack, timeout} !== 4'b1000 || cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL midrun_reset: got ctl %b count %0d want 1000 0", {core_reset, busy, ack, timeout}, cycle_count);
        end
        checks++;
        if (prog_idx !== 2'd0 || start_addr !== exp_base[0]) begin
            errors++;
            $display("FAIL midrun_prog: got idx %0d addr %h want 0 %h", prog_idx, start_addr, exp_base[0]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL midrun_discard: got busy %b ack %b want 0 0", busy, ack);
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_timeout();
        test_ack_at_limit();
        test_prog_wrap();
        test_start_held();
        test_abort();
        test_random();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Run controller for the single-cycle 9-bit core. Accepts a four-phase Start/Ack handshake from the bench or host and holds the core in reset between runs. On each run it releases the core at the start address of the current program, counts execution cycles, and detects completion through the core's done flag or a watchdog timeout. It sits directly above the core top level and drives that level's active-high reset.

## Interface
Parameters:
- NUM_PROGS, 3: number of programs in instruction ROM; ProgIdx wraps at NUM_PROGS-1.
- RST_CYCLES, 2: cycles the core reset is held at the start of each run (≥1).
- MAX_CYCLES, 16'hFFFF: watchdog limit on RUN cycles (≥1).
- CNT_W, 16: cycle counter width.

Ports:
- Clk  in  1  clock; posedge only.
- Reset  in  1  one clock; reset is synchronous and active-low; Reset=0 at a posedge resets the block.
- Start  in  1  run request, level; sampled only in IDLE and DONE.
- Abort  in  1  cancel current run; acted on in RESET/RUN only.
- CoreAck  in  1  core done flag (combinational from core); sampled only in RUN.
- CoreReset  out  1  active-high reset to core; 1 in every state except RUN.
- StartAddr  out  8  PROG_BASE[ProgIdx], presented to core PC reset value.
- ProgIdx  out  2  program selected for the next/current run.
- Busy  out  1  1 in RESET and RUN.
- Ack  out  1  1 in DONE only.
- Timeout  out  1  sticky: last run ended by watchdog.
- CycleCount  out  CNT_W  RUN cycles of last/current run; saturates at MAX_CYCLES.

## Operation
States: IDLE, RESET, RUN, DONE.
- IDLE: Start=1 → RESET. This clears CycleCount and Timeout and loads the reset-hold counter with RST_CYCLES-1.
- RESET: CoreReset=1 and the hold counter decrements. Abort=1 → IDLE. Hold counter 0 → RUN.
- RUN: CoreReset=0 and CycleCount increments every cycle, including the cycle CoreAck is seen.
  - Abort=1 (priority over CoreAck): → IDLE; ProgIdx unchanged; CycleCount frozen.
  - CoreAck=1: → DONE, Timeout=0.
  - CoreAck=0 and CycleCount+1==MAX_CYCLES: → DONE, Timeout=1.
  - CoreAck=1 in the same cycle as the limit: ack wins, Timeout=0.
- DONE: Ack=1; CycleCount and Timeout are frozen. Start=0 → IDLE, and ProgIdx advances (NUM_PROGS-1 → 0). Start held at 1 keeps the block in DONE; no re-trigger without a low phase.
- Start changes while in RESET or RUN are ignored.
- Abort in IDLE or DONE is ignored.
- Reset (any state) → IDLE with all outputs at reset values. A run in progress is discarded, not completed.

Reset values:
- State: IDLE.
- Outputs: CoreReset=1, Busy=0, Ack=0, Timeout=0, CycleCount=0, ProgIdx=0, StartAddr=PROG_BASE[0].

All outputs are registered or decoded from registered state only; no combinational path from any input to any output.

## Timing
- Start=1 sampled in IDLE at edge t: from t+1, Busy=1 and CoreReset=1 for exactly RST_CYCLES cycles.
- First RUN cycle is t+1+RST_CYCLES.
- CoreAck=1 on the Nth RUN cycle (N=1 first): DONE from the next edge, with Ack=1 and CycleCount=N.
- Timeout: DONE entered after exactly MAX_CYCLES RUN cycles, with CycleCount=MAX_CYCLES.
- Start=0 sampled in DONE: Ack drops next cycle, ProgIdx/StartAddr update the same edge.
- Minimum turnaround DONE → next RESET is 2 edges: DONE→IDLE on Start=0, then IDLE→RESET on Start=1.
- Abort latency is one cycle: CoreReset=1 on the following cycle.

## Structure
Package prog_seq_pkg:
- State enum (IDLE, RESET, RUN, DONE).
- PROG_BASE[0:NUM_PROGS-1] 8-bit start-address array.
- Default CNT_W, MAX_CYCLES, RST_CYCLES.

Sub-module sat_counter (width, limit, clear, enable → count, at_limit) implements CycleCount. The reset-hold counter is inline.

## Test plan
- Reset release → CoreReset=1, Busy=0, Ack=0, ProgIdx=0, CycleCount=0 held until Start.
- Start pulse high, RST_CYCLES=2, CoreAck raised on 5th RUN cycle → CoreReset high exactly 2 cycles, Ack=1, CycleCount=5, Timeout=0; Start low → ProgIdx=1 next cycle.
- MAX_CYCLES=8, CoreAck never raised → DONE after 8 RUN cycles, CycleCount=8, Timeout=1; the next accepted Start clears Timeout.
- Three completed runs → ProgIdx 0→1→2→0 and StartAddr follows PROG_BASE.
- Start held high through DONE → Ack stays 1 and no new run until Start=0 then 1; Abort on 3rd RUN cycle → IDLE next cycle, CycleCount=3, ProgIdx unchanged.
- Reset=0 mid-RUN → IDLE with all reset values next cycle; CoreAck with limit in same cycle → Timeout=0.
